// File: rtl/framer_pkg.sv
// Shared types for the nibble framer: nibble width, FSM states, nibble type.
package framer_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic {HUNT, SHIFT} framer_state_t;

    typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/nibble_framer_if.sv
// Serial bit strobe in, nibble valid/ready out; master is the framer, slave the bit source and LUT side.
interface nibble_framer_if;
    import framer_pkg::*;

    logic    ser_in;
    logic    ser_valid;
    logic    sync;
    nibble_t x;
    logic    x_valid;
    logic    x_ready;

    modport master (
        input  ser_in, ser_valid, sync, x_ready,
        output x, x_valid
    );

    modport slave (
        output ser_in, ser_valid, sync, x_ready,
        input  x, x_valid
    );
endinterface

// File: rtl/nibble_shreg.sv
// 4-bit serial shift register; clr empties it before the shift of the same cycle.
// Latency: nxt is the combinational next value, q updates on the clock edge.
// Backpressure: none, shifts whenever shift_en is high.
module nibble_shreg
    import framer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr,
    input  logic    shift_en,
    input  logic    din,
    output nibble_t q,
    output nibble_t nxt
);
    nibble_t base;

    always_comb begin
        base = clr ? '0 : q;
        nxt  = base;
        if (shift_en) begin
            if (MSB_FIRST)
                nxt = {base[NIBBLE_W-2:0], din};
            else
                nxt = {din, base[NIBBLE_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= nxt;
    end
endmodule

// File: rtl/nibble_framer.sv
// Serial-to-nibble framer with sync alignment; optional SLIDING_WINDOW_EN emits a nibble per bit once primed.
// Latency: x/x_valid update one clk after the completing bit.
// Backpressure: x held until x_ready; a completion against a stalled x is dropped and sets sticky overrun.
module nibble_framer
    import framer_pkg::*;
#(
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CNT_W        = 8,
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    nibble_framer_if.master  bus,
    input  logic             clr_ovr,
    output logic             overrun,
    output logic [CNT_W-1:0] nib_cnt
);
    framer_state_t state, state_nxt;
    logic [1:0]    bit_cnt, bit_cnt_nxt, bit_cnt_eff;
    logic          accept, complete, transfer;
    nibble_t       shreg_q, shreg_nxt;

    nibble_t          x_nxt;
    logic             x_valid_nxt, overrun_nxt;
    logic [CNT_W-1:0] nib_cnt_nxt;

`ifdef SLIDING_WINDOW_EN
    logic primed, primed_nxt, primed_eff;
`endif

    nibble_shreg #(.MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.sync),
        .shift_en (accept),
        .din      (bus.ser_in),
        .q        (shreg_q),
        .nxt      (shreg_nxt)
    );

    // A bit arriving with sync is bit 0 of the freshly aligned nibble.
    assign accept      = bus.ser_valid && (state == SHIFT || bus.sync);
    assign bit_cnt_eff = bus.sync ? 2'd0 : bit_cnt;
    assign transfer    = bus.x_valid && bus.x_ready;

`ifdef SLIDING_WINDOW_EN
    assign primed_eff = bus.sync ? 1'b0 : primed;
    assign complete   = accept && (primed_eff || bit_cnt_eff == 2'd3);
    assign primed_nxt = primed_eff || complete;
`else
    assign complete = accept && (bit_cnt_eff == 2'd3);
`endif

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt_eff;
        x_nxt       = bus.x;
        x_valid_nxt = bus.x_valid;
        overrun_nxt = overrun;
        nib_cnt_nxt = nib_cnt;

        if (bus.sync)
            state_nxt = SHIFT;
        if (accept)
            bit_cnt_nxt = bit_cnt_eff + 2'd1;

        if (clr_ovr)
            overrun_nxt = 1'b0;

        if (complete && (!bus.x_valid || bus.x_ready)) begin
            x_nxt       = shreg_nxt;
            x_valid_nxt = 1'b1;
            nib_cnt_nxt = nib_cnt + CNT_W'(1);
        end else if (complete) begin
            overrun_nxt = 1'b1;
        end else if (transfer) begin
            x_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQUIRE_SYNC ? HUNT : SHIFT;
            bit_cnt     <= 2'd0;
            bus.x       <= '0;
            bus.x_valid <= 1'b0;
            overrun     <= 1'b0;
            nib_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            bus.x       <= x_nxt;
            bus.x_valid <= x_valid_nxt;
            overrun     <= overrun_nxt;
            nib_cnt     <= nib_cnt_nxt;
        end
    end

`ifdef SLIDING_WINDOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            primed <= 1'b0;
        else
            primed <= primed_nxt;
    end
`endif
endmodule

// File: tb/tb_nibble_framer.sv
// Directed bench for nibble_framer: MSB-first/sync-required instance plus an LSB-first, no-sync, CNT_W=2 instance.
module tb_nibble_framer;
    import framer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_ovr_a = 1'b0;
    logic clr_ovr_b = 1'b0;
    logic       overrun_a, overrun_b;
    logic [7:0] nib_cnt_a;
    logic [1:0] nib_cnt_b;

    int n_chk = 0;
    int n_bad = 0;

    nibble_framer_if a ();
    nibble_framer_if b ();

    nibble_framer #(.MSB_FIRST(1'b1), .CNT_W(8), .REQUIRE_SYNC(1'b1)) u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (a),
        .clr_ovr (clr_ovr_a),
        .overrun (overrun_a),
        .nib_cnt (nib_cnt_a)
    );

    nibble_framer #(.MSB_FIRST(1'b0), .CNT_W(2), .REQUIRE_SYNC(1'b0)) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b),
        .clr_ovr (clr_ovr_b),
        .overrun (overrun_b),
        .nib_cnt (nib_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one cycle of serial input on instance a; returns #1 after the capturing edge.
    task automatic step_a(input logic bit_in, input logic vld, input logic syn);
        a.ser_in    = bit_in;
        a.ser_valid = vld;
        a.sync      = syn;
        @(posedge clk);
        #1;
        a.ser_valid = 1'b0;
        a.sync      = 1'b0;
        a.ser_in    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        a.ser_in = 0; a.ser_valid = 0; a.sync = 0; a.x_ready = 1;
        b.ser_in = 0; b.ser_valid = 0; b.sync = 0; b.x_ready = 1;

        // Reset values
        #2;
        check("rst_x",       32'(a.x), 32'h0);
        check("rst_x_valid", 32'(a.x_valid), 32'h0);
        check("rst_overrun", 32'(overrun_a), 32'h0);
        check("rst_nib_cnt", 32'(nib_cnt_a), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;

        // 1: sync + 1,0,1,1 MSB first -> 4'hB one clk after 4th bit
        step_a(1, 1, 1);
        step_a(0, 1, 0);
        step_a(1, 1, 0);
        check("t1_no_early_valid", 32'(a.x_valid), 32'h0);
        step_a(1, 1, 0);
        check("t1_x",       32'(a.x), 32'hB);
        check("t1_x_valid", 32'(a.x_valid), 32'h1);
        check("t1_nib_cnt", 32'(nib_cnt_a), 32'h1);
        step_a(0, 0, 0);
        check("t1_consumed_valid", 32'(a.x_valid), 32'h0);
        check("t1_x_hold",         32'(a.x), 32'hB);

        // 2: no sync after reset -> bits ignored
        do_reset();
        for (int i = 0; i < 4; i++) step_a(1, 1, 0);
        step_a(0, 0, 0);
        check("t2_x_valid", 32'(a.x_valid), 32'h0);
        check("t2_nib_cnt", 32'(nib_cnt_a), 32'h0);

        // 3: stalled downstream, 4'h3 then 4'hC -> overrun
        do_reset();
        a.x_ready = 0;
        step_a(0, 1, 1); step_a(0, 1, 0); step_a(1, 1, 0); step_a(1, 1, 0);
        check("t3_first_x", 32'(a.x), 32'h3);
        step_a(1, 1, 0); step_a(1, 1, 0); step_a(0, 1, 0); step_a(0, 1, 0);
        check("t3_x_held",   32'(a.x), 32'h3);
        check("t3_overrun",  32'(overrun_a), 32'h1);
        check("t3_nib_cnt",  32'(nib_cnt_a), 32'h1);
        clr_ovr_a = 1;
        step_a(0, 0, 0);
        clr_ovr_a = 0;
        check("t3_ovr_clr", 32'(overrun_a), 32'h0);
        step_a(1, 1, 0); step_a(1, 1, 0); step_a(1, 1, 0);
        clr_ovr_a = 1;
        step_a(1, 1, 0);
        clr_ovr_a = 0;
        check("t3_set_wins", 32'(overrun_a), 32'h1);
        a.x_ready = 1;
        step_a(0, 0, 0);
        check("t3_drain_valid", 32'(a.x_valid), 32'h0);
        check("t3_drain_x",     32'(a.x), 32'h3);

        // 4: partial nibble discarded by sync
        do_reset();
        step_a(1, 1, 1); step_a(0, 1, 0);
        step_a(0, 1, 1); step_a(1, 1, 0); step_a(1, 1, 0);
        check("t4_not_yet", 32'(a.x_valid), 32'h0);
        step_a(0, 1, 0);
        check("t4_x",       32'(a.x), 32'h6);
        check("t4_nib_cnt", 32'(nib_cnt_a), 32'h1);

        // 5a: completion coincides with transfer -> load, no overrun
        do_reset();
        a.x_ready = 0;
        step_a(1, 1, 1); step_a(0, 1, 0); step_a(1, 1, 0); step_a(0, 1, 0);
        check("t5_first_x", 32'(a.x), 32'hA);
        step_a(0, 1, 0); step_a(1, 1, 0); step_a(0, 1, 0);
        check("t5_hold_valid", 32'(a.x_valid), 32'h1);
        a.x_ready = 1;
        step_a(1, 1, 0);
        check("t5_x",       32'(a.x), 32'h5);
        check("t5_valid",   32'(a.x_valid), 32'h1);
        check("t5_overrun", 32'(overrun_a), 32'h0);
        check("t5_nib_cnt", 32'(nib_cnt_a), 32'h2);

        // 5b: LSB first, no sync needed, CNT_W=2 wraps after 5 nibbles
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            logic [3:0] val;
            val = 4'(v);
            for (int i = 0; i < 4; i++) begin
                b.ser_in    = val[i];
                b.ser_valid = 1'b1;
                @(posedge clk);
                #1;
                b.ser_valid = 1'b0;
            end
            if (v == 1) check("t5b_first_x", 32'(b.x), 32'h1);
        end
        check("t5b_x",       32'(b.x), 32'h5);
        check("t5b_valid",   32'(b.x_valid), 32'h1);
        check("t5b_nib_cnt", 32'(nib_cnt_b), 32'h1);
        check("t5b_overrun", 32'(overrun_b), 32'h0);

        // 6: sync, 1,0,0,1,1 then async reset mid-stream
        do_reset();
        step_a(1, 1, 1); step_a(0, 1, 0); step_a(0, 1, 0); step_a(1, 1, 0);
        check("t6_x0", 32'(a.x), 32'h9);
        step_a(1, 1, 0);
`ifdef SLIDING_WINDOW_EN
        check("t6_x1",       32'(a.x), 32'h3);
        check("t6_valid1",   32'(a.x_valid), 32'h1);
        check("t6_nib_cnt",  32'(nib_cnt_a), 32'h2);
`else
        check("t6_x1",       32'(a.x), 32'h9);
        check("t6_valid1",   32'(a.x_valid), 32'h0);
        check("t6_nib_cnt",  32'(nib_cnt_a), 32'h1);
`endif
        step_a(0, 1, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_x",       32'(a.x), 32'h0);
        check("t6_rst_valid",   32'(a.x_valid), 32'h0);
        check("t6_rst_overrun", 32'(overrun_a), 32'h0);
        check("t6_rst_nib_cnt", 32'(nib_cnt_a), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Reset mid-nibble forces a fresh sync
        for (int i = 0; i < 4; i++) step_a(1, 1, 0);
        check("t6_need_sync", 32'(a.x_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
